sequenciador_deslocamento: RTL and testbench
============================================

Name: sequenciador_deslocamento

Overview:
- Multi-cycle shift sequencer in the MIC datapath.
- Performs a shift of 0–31 bit positions by repeatedly issuing the primitive shifter operations, one per clock:
  - SLL8: logical left by 8.
  - SRA1: arithmetic right by 1.
  - SLL1: logical left by 1.
- Holds the working operand in an internal register.
- Reports progress to the control unit through a start/busy/done handshake.
- Exposes the per-cycle shifter code, so the shared shifter encoding can be traced.

Parameters:
- LARGURA, 32, datapath width in bits. Only 32 is supported.
- AMT_W, 5, width of the shift-amount field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE.
- dir  input  1  0 = logical left shift, 1 = arithmetic right shift.
- amount  input  5  number of bit positions, 0–31.
- data_in  input  32  operand, captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse; result is valid.
- data_out  output  32  result register. Holds its value until the next accepted start completes.
- desl_code  output  2  shifter code applied this cycle: 0 = pass, 1 = SLL8, 2 = SRA1, 3 = SLL1.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy = 0; done = 0; data_out = 0; desl_code = 0; internal remaining counter = 0; working register = 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start = 1:
  - Capture data_in, dir and amount into internal registers.
  - amount = 0: go to DONE.
  - amount ≠ 0: go to SHIFT with busy = 1.
  - start = 0: stay in IDLE; desl_code = 0.
- SHIFT, one operation per cycle:
  - dir = 0 and remaining ≥ 8: apply SLL8, remaining −= 8, desl_code = 1.
  - dir = 0 and remaining < 8: apply SLL1, remaining −= 1, desl_code = 3.
  - dir = 1: apply SRA1 (sign bit replicated), remaining −= 1, desl_code = 2.
  - When the updated remaining equals 0, go to DONE.
- DONE:
  - data_out ← working register; done = 1 for exactly this cycle; busy = 0; desl_code = 0.
  - Next state is IDLE.
- Step count:
  - Left: floor(amount/8) + (amount mod 8).
  - Right: amount.
- Latency: with start accepted at edge t, done is high in cycle t+1+steps. For amount = 0, done is high in cycle t+1.
- start while in SHIFT or DONE: ignored, no queuing. The captured operands are unaffected.
- Back-to-back operation: start may be accepted in the IDLE cycle that immediately follows DONE.
- Reset mid-operation: the operation is aborted immediately, no done is produced, and all outputs return to their reset values.
- amount is a 5-bit field; values ≥ 32 cannot occur.

Optional Feature:
- Macro: DESL_ABORT_EN.
- When defined:
  - Adds an input port abort (1 bit).
  - abort = 1 in SHIFT: return to IDLE at the next edge; busy = 0; no done pulse; data_out keeps its previous value.
  - abort in IDLE or DONE: no effect.
  - abort has priority over a SHIFT step completing in the same cycle.
- When not defined:
  - The abort port does not exist.
  - Every accepted operation runs to completion unless reset is asserted.

Test Plan:
1. dir = 0, amount = 13, data_in = 0x00000001 → desl_code sequence 1,3,3,3,3,3 (6 steps); done in cycle t+7; data_out = 0x00002000.
2. dir = 1, amount = 4, data_in = 0x80000000 → desl_code 2 for 4 cycles; done in cycle t+5; data_out = 0xF8000000. Repeat with data_in = 0x40000000 → data_out = 0x04000000.
3. amount = 0, data_in = 0xDEADBEEF → done in cycle t+1; busy never asserted; data_out = 0xDEADBEEF.
4. dir = 0, amount = 31, data_in = 0x00000001 → 10 steps (3×SLL8 + 7×SLL1); data_out = 0x80000000. A second start pulsed mid-operation is ignored, and there is exactly one done.
5. Start SLL by 20 on 0x12345678, then assert reset after 2 SHIFT cycles → outputs are 0 immediately and no done is produced. A subsequent start with dir = 1, amount = 1, data_in = 0xFFFFFFFE → data_out = 0xFFFFFFFF.
6. With DESL_ABORT_EN defined: SRA by 10, abort after 3 cycles → IDLE on the next edge; no done; data_out keeps its prior value.

Source files
------------

// File: rtl/sequenciador_deslocamento.sv
// Multi-cycle shift sequencer: builds a 0..31-bit shift out of the primitive
// shifter operations SLL8, SRA1 and SLL1, issuing one per clock.
// Optional feature macro: DESL_ABORT_EN (adds an abort input that cancels a
// shift in progress).
module sequenciador_deslocamento #(
  parameter int LARGURA = 32,
  parameter int AMT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [AMT_W-1:0]   amount,
  input  logic [LARGURA-1:0] data_in,
`ifdef DESL_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] data_out,
  output logic [1:0]         desl_code
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] C_PASS = 2'd0;
  localparam logic [1:0] C_SLL8 = 2'd1;
  localparam logic [1:0] C_SRA1 = 2'd2;
  localparam logic [1:0] C_SLL1 = 2'd3;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [LARGURA-1:0] work_q, work_d;
  logic [LARGURA-1:0] out_q, out_d;
  logic [1:0]         code;
  logic               abort_req;

`ifdef DESL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State, operand and result registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: one primitive shift per SHIFT cycle. The result register
  // is loaded on the transition into DONE so it is valid while done is high.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    work_d  = work_q;
    out_d   = out_q;
    code    = C_PASS;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = data_in;
          dir_d  = dir;
          rem_d  = amount;
          if (amount == '0) begin
            out_d   = data_in;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort_req) begin
          // Abort wins over a step that would finish this cycle.
          state_d = IDLE;
        end else begin
          if (dir_q) begin
            work_d = {work_q[LARGURA-1], work_q[LARGURA-1:1]};
            rem_d  = rem_q - AMT_W'(1);
            code   = C_SRA1;
          end else if (rem_q >= AMT_W'(8)) begin
            work_d = {work_q[LARGURA-9:0], 8'h00};
            rem_d  = rem_q - AMT_W'(8);
            code   = C_SLL8;
          end else begin
            work_d = {work_q[LARGURA-2:0], 1'b0};
            rem_d  = rem_q - AMT_W'(1);
            code   = C_SLL1;
          end
          if (rem_d == '0) begin
            out_d   = work_d;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign data_out  = out_q;
  assign desl_code = code;

endmodule

// File: tb/tb_sequenciador_deslocamento.sv
// Directed bench for sequenciador_deslocamento. Define DESL_ABORT_EN to also
// exercise the abort input.
module tb_sequenciador_deslocamento;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic [4:0]  amount;
  logic [31:0] data_in;
`ifdef DESL_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [1:0]  desl_code;

  int total = 0;
  int bad   = 0;

  sequenciador_deslocamento #(.LARGURA(32), .AMT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .amount    (amount),
    .data_in   (data_in),
`ifdef DESL_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .desl_code (desl_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and observes it until done (bounded). Edges are
  // counted from the accepting edge; desl_code is recorded for each busy cycle.
  // After done, a few more cycles are watched for stray done pulses.
  task automatic do_op(input logic d, input logic [4:0] a, input logic [31:0] x,
                       input int mid_start_at,
                       output int edges, output logic [63:0] codes,
                       output int nbusy, output int ndone);
    dir = d; amount = a; data_in = x; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1; codes = '0; nbusy = 0; ndone = 0;
    while (!done && edges < 60) begin
      if (busy && nbusy < 32) begin
        codes[2*nbusy +: 2] = desl_code;
        nbusy++;
      end
      if (edges == mid_start_at) begin
        start = 1'b1; dir = 1'b1; amount = 5'd3; data_in = 32'hFFFF_FFFF;
      end
      tick();
      start = 1'b0;
      edges++;
    end
    if (done) ndone = 1;
  endtask

  task automatic count_extra_done(input int cycles, inout int ndone);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; data_in = '0;
`ifdef DESL_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    total++;
    if ({busy, done, data_out, desl_code} !== 36'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b data_out=%h code=%0d, want all zero",
               busy, done, data_out, desl_code);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_left_13();
    int e, nb, nd; logic [63:0] c;
    logic [1:0] exp_c [6] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    do_op(1'b0, 5'd13, 32'h0000_0001, -1, e, c, nb, nd);
    total++;
    if (e !== 7 || nb !== 6) begin
      bad++; $display("FAIL left13_latency: got edges=%0d busy=%0d, want 7 and 6", e, nb);
    end
    total++;
    if (data_out !== 32'h0000_2000) begin
      bad++; $display("FAIL left13_data: got %h, want 00002000", data_out);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (c[2*i +: 2] !== exp_c[i]) begin
        bad++; $display("FAIL left13_code%0d: got %0d, want %0d", i, c[2*i +: 2], exp_c[i]);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL left13_busy_at_done: got %b, want 0", busy);
    end
    tick();
  endtask

  task automatic test_right_4();
    int e, nb, nd; logic [63:0] c;
    do_op(1'b1, 5'd4, 32'h8000_0000, -1, e, c, nb, nd);
    total++;
    if (e !== 5 || data_out !== 32'hF800_0000 || c[7:0] !== 8'hAA) begin
      bad++; $display("FAIL right4_neg: got edges=%0d data=%h codes=%h, want 5 F8000000 aa",
                      e, data_out, c[7:0]);
    end
    tick();
    do_op(1'b1, 5'd4, 32'h4000_0000, -1, e, c, nb, nd);
    total++;
    if (e !== 5 || data_out !== 32'h0400_0000) begin
      bad++; $display("FAIL right4_pos: got edges=%0d data=%h, want 5 04000000", e, data_out);
    end
    tick();
  endtask

  task automatic test_amount_zero();
    int e, nb, nd; logic [63:0] c;
    do_op(1'b0, 5'd0, 32'hDEAD_BEEF, -1, e, c, nb, nd);
    total++;
    if (e !== 1 || nb !== 0 || data_out !== 32'hDEAD_BEEF || desl_code !== 2'd0) begin
      bad++; $display("FAIL amount0: got edges=%0d busy_cycles=%0d data=%h code=%0d, want 1 0 deadbeef 0",
                      e, nb, data_out, desl_code);
    end
    tick();
  endtask

  task automatic test_left_31_ignore_start();
    int e, nb, nd; logic [63:0] c; logic [1:0] ec;
    do_op(1'b0, 5'd31, 32'h0000_0001, 4, e, c, nb, nd);
    count_extra_done(4, nd);
    total++;
    if (e !== 11 || nb !== 10) begin
      bad++; $display("FAIL left31_latency: got edges=%0d busy=%0d, want 11 and 10", e, nb);
    end
    total++;
    if (data_out !== 32'h8000_0000) begin
      bad++; $display("FAIL left31_data: got %h, want 80000000", data_out);
    end
    total++;
    if (nd !== 1) begin
      bad++; $display("FAIL left31_done_count: got %0d, want 1", nd);
    end
    for (int i = 0; i < 10; i++) begin
      ec = (i < 3) ? 2'd1 : 2'd3;
      total++;
      if (c[2*i +: 2] !== ec) begin
        bad++; $display("FAIL left31_code%0d: got %0d, want %0d", i, c[2*i +: 2], ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, nb, nd; logic [63:0] c;
    do_op(1'b0, 5'd8, 32'h0000_0001, -1, e, c, nb, nd);
    total++;
    if (e !== 2 || data_out !== 32'h0000_0100) begin
      bad++; $display("FAIL b2b_first: got edges=%0d data=%h, want 2 00000100", e, data_out);
    end
    // Now in IDLE right after DONE: start is accepted here.
    tick();
    do_op(1'b1, 5'd1, 32'h8000_0000, -1, e, c, nb, nd);
    total++;
    if (e !== 2 || data_out !== 32'hC000_0000) begin
      bad++; $display("FAIL b2b_second: got edges=%0d data=%h, want 2 c0000000", e, data_out);
    end
    // start raised while in DONE must be ignored.
    start = 1'b1; dir = 1'b0; amount = 5'd5; data_in = 32'h1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'hC000_0000) begin
      bad++; $display("FAIL start_in_done: got busy=%b done=%b data=%h, want 0 0 c0000000",
                      busy, done, data_out);
    end
  endtask

  task automatic test_reset_midop();
    int e, nb, nd;
    dir = 1'b0; amount = 5'd20; data_in = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, data_out, desl_code} !== 36'd0) begin
      bad++; $display("FAIL reset_midop: got busy=%b done=%b data=%h code=%0d, want all zero",
                      busy, done, data_out, desl_code);
    end
    tick();
    reset = 1'b0;
    nd = 0;
    count_extra_done(6, nd);
    total++;
    if (nd !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_no_done: got done_count=%0d busy=%b, want 0 0", nd, busy);
    end
    begin
      logic [63:0] c;
      do_op(1'b1, 5'd1, 32'hFFFF_FFFE, -1, e, c, nb, nd);
    end
    total++;
    if (e !== 2 || data_out !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL after_reset_op: got edges=%0d data=%h, want 2 ffffffff", e, data_out);
    end
    tick();
  endtask

`ifdef DESL_ABORT_EN
  task automatic test_abort();
    int nd;
    // data_out holds ffffffff from the previous operation.
    abort = 1'b1;   // no effect in IDLE
    tick();
    abort = 1'b0;
    dir = 1'b1; amount = 5'd10; data_in = 32'h8000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL abort: got busy=%b done=%b data=%h, want 0 0 ffffffff",
                      busy, done, data_out);
    end
    nd = 0;
    count_extra_done(12, nd);
    total++;
    if (nd !== 0 || data_out !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL abort_no_done: got done_count=%0d data=%h, want 0 ffffffff", nd, data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_left_13();
    test_right_4();
    test_amount_zero();
    test_left_31_ignore_start();
    test_back_to_back();
    test_reset_midop();
`ifdef DESL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
